// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter slice.
//   REQ_CORE / REQ_DMA : requester indices into the req/gnt/rvalid vectors
//   NUM_REQ            : number of requesters
//   DATA_W             : memory word width (64-bit words)
//   cnt_width()        : bits needed to hold a saturating count 0..max
package dmem_pkg;

    localparam int unsigned REQ_CORE = 0;
    localparam int unsigned REQ_DMA  = 1;
    localparam int unsigned NUM_REQ  = 2;
    localparam int unsigned DATA_W   = 64;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Arbitration decision for the data-memory arbiter (purely combinational).
// Optional feature macro: DMEM_ARB_RR_EN selects round-robin contention
// resolution; when undefined the core (requester 0) wins contention.
// Ports:
//   req      in  per-requester request (bit 0 core, bit 1 DMA)
//   last_gnt in  index of the most recently granted requester
//   wait_cnt in  cycles the DMA requester has been refused (saturating)
//   gnt      out one-hot-or-zero grant
module dmem_arb_pick
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned WAIT_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_gnt,
    input  logic [WAIT_W-1:0]  wait_cnt,
    output logic [NUM_REQ-1:0] gnt
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

`ifndef DMEM_ARB_RR_EN
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

    always_comb begin
        gnt = '0;
        if (req[REQ_CORE] && req[REQ_DMA]) begin
            if (wait_cnt == WAIT_MAX) begin
                // Starvation override: DMA has been refused long enough.
                gnt[REQ_DMA] = 1'b1;
            end else begin
`ifdef DMEM_ARB_RR_EN
                // last_gnt holds the index of the previous winner; the other one goes now.
                if (last_gnt) gnt[REQ_CORE] = 1'b1;
                else          gnt[REQ_DMA]  = 1'b1;
`else
                gnt[REQ_CORE] = 1'b1;
`endif
            end
        end else begin
            // Zero or one requester: grant passes straight through.
            gnt = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: core MEM stage (0) and DMA/loader (1)
// share a single-port 64-bit-word memory with one-cycle read latency.
// Optional feature macro: DMEM_ARB_RR_EN (round-robin contention, see
// dmem_arb_pick); default build is fixed priority with DMA starvation guard.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   req, we           per-requester request / write enable
//   addr, wdata       per-requester word address / store data (packed slices)
//   gnt               one-hot-or-zero grant, access accepted this cycle
//   rvalid, rdata     load response strobe (cycle after grant) and data
//   mem_en, mem_we    memory strobe / write enable
//   mem_addr, mem_wdata, mem_rdata  memory address / write data / read data
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         we,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int unsigned       WAIT_W   = cnt_width(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic                 last_gnt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [NUM_REQ-1:0]   rd_pend;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic                 sel_dma;

    dmem_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .wait_cnt (wait_cnt),
        .gnt      (pick_gnt)
    );

    // Reset masks the grant and the response strobe combinationally, so a
    // load granted just before reset never reports rvalid.
    assign gnt    = rst ? pick_gnt : '0;
    assign rvalid = rst ? rd_pend  : '0;
    assign rdata  = mem_rdata;

    assign sel_dma   = gnt[REQ_DMA];
    assign mem_en    = |gnt;
    assign mem_we    = |(gnt & we);
    assign mem_addr  = sel_dma ? addr[REQ_DMA*ADDR_W +: ADDR_W]
                               : addr[REQ_CORE*ADDR_W +: ADDR_W];
    assign mem_wdata = sel_dma ? wdata[REQ_DMA*DATA_W +: DATA_W]
                               : wdata[REQ_CORE*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_gnt <= 1'b1;
            wait_cnt <= '0;
            rd_pend  <= '0;
        end else begin
            rd_pend <= gnt & ~we;
            if (mem_en) last_gnt <= sel_dma;
            if (req[REQ_DMA] && !gnt[REQ_DMA]) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of the arbitration rules.
// Honours DMEM_ARB_RR_EN the same way the design does.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW = 10;
    localparam int MW = 4;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    req, we;
    logic [2*AW-1:0] addr;
    logic [127:0]  wdata;
    logic [1:0]    gnt, rvalid;
    logic [63:0]   rdata, mem_wdata, mem_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;

    dmem_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [63:0] init_val(input logic [AW-1:0] a);
        return 64'(a) * 64'd6 - 64'd1;   // word 5 holds 29
    endfunction

    // Memory attached to the DUT: one-cycle read latency.
    logic [63:0] mem [0:1023];
    bit          memv [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr]  <= mem_wdata;
                memv[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= memv[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
            end
        end
    end

    // Reference model state
    int          total = 0, bad = 0;
    int          m_last, m_wait, m_pend, widx;
    logic [63:0] m_pend_data;
    logic [63:0] sh [0:1023];
    bit          shv [0:1023];
    logic        cur_r;
    logic [1:0]  cur_req;
    logic [1:0]  e_gnt, e_rvalid;
    logic        e_we;
    logic [AW-1:0] e_addr;
    logic [63:0] e_rdata, e_wdata;

    function automatic logic [63:0] sh_read(input logic [AW-1:0] a);
        return shv[a] ? sh[a] : init_val(a);
    endfunction

    // Apply inputs just after a rising edge, compute expectations, settle to the falling edge.
    task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] w,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1);
        rst = r; req = rq; we = w; addr = {a1, a0}; wdata = {d1, d0};
        cur_r = r; cur_req = rq;
        e_gnt = 2'b00;
        if (r) begin
            if (rq == 2'b01 || rq == 2'b10) e_gnt = rq;
            else if (rq == 2'b11) begin
                if (m_wait >= MW) e_gnt = 2'b10;
                else begin
`ifdef DMEM_ARB_RR_EN
                    e_gnt = (m_last == 1) ? 2'b01 : 2'b10;
`else
                    e_gnt = 2'b01;
`endif
                end
            end
        end
        e_rvalid = (r && m_pend >= 0) ? ((m_pend == 0) ? 2'b01 : 2'b10) : 2'b00;
        e_rdata  = m_pend_data;
        widx     = (e_gnt == 2'b10) ? 1 : 0;
        e_we     = (e_gnt != 2'b00) && w[widx];
        e_addr   = (widx == 1) ? a1 : a0;
        e_wdata  = (widx == 1) ? d1 : d0;
        #4;
    endtask

    // Commit the cycle into the model and move to just after the next rising edge.
    task automatic advance();
        if (!cur_r) begin
            m_last = 1; m_wait = 0; m_pend = -1;
        end else begin
            m_pend = -1;
            if (e_gnt != 2'b00) begin
                if (e_we) begin
                    sh[e_addr] = e_wdata; shv[e_addr] = 1'b1;
                end else begin
                    m_pend = widx; m_pend_data = sh_read(e_addr);
                end
                m_last = widx;
            end
            if (cur_req[1] && e_gnt != 2'b10) m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
            else m_wait = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        drive(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
        advance();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b11, 2'b00, 10'd1, 10'd2, '0, '0);
            total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
            total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
            total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
            total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
            advance();
        end
    endtask

    task automatic test_single_load();
        pulse_reset();
        drive(1'b1, 2'b01, 2'b00, 10'd5, 10'd0, '0, '0);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL load_gnt: got %b want 01", gnt); end
        total++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL load_strobe: got en=%b we=%b want en=1 we=0", mem_en, mem_we); end
        total++; if (mem_addr !== 10'd5) begin bad++; $display("FAIL load_addr: got %0d want 5", mem_addr); end
        advance();
        drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
        total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL load_rvalid: got %b want 01", rvalid); end
        total++; if (rdata !== 64'd29) begin bad++; $display("FAIL load_rdata: got %0d want 29", rdata); end
        advance();
        drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL load_rvalid_once: got %b want 00", rvalid); end
        advance();
    endtask

    task automatic test_contention();
        logic [1:0] seq [0:6];
        seq[0] = 2'b01; seq[1] = 2'b01; seq[2] = 2'b01; seq[3] = 2'b01;
        seq[4] = 2'b10; seq[5] = 2'b01; seq[6] = 2'b01;
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 2'b11, 2'b00, 10'd8, 10'd9, '0, '0);
            total++; if (gnt !== e_gnt) begin bad++; $display("FAIL contend_gnt[%0d]: got %b want %b", i, gnt, e_gnt); end
`ifndef DMEM_ARB_RR_EN
            total++; if (gnt !== seq[i]) begin bad++; $display("FAIL fixed_seq[%0d]: got %b want %b", i, gnt, seq[i]); end
`endif
            total++; if (rvalid !== e_rvalid) begin bad++; $display("FAIL contend_rvalid[%0d]: got %b want %b", i, rvalid, e_rvalid); end
            advance();
        end
    endtask

`ifdef DMEM_ARB_RR_EN
    task automatic test_round_robin();
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'b11, 2'b00, 10'd1, 10'd2, '0, '0);
            total++;
            if (gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL rr_seq[%0d]: got %b want %b", i, gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            advance();
        end
    endtask
`endif

    task automatic test_store_load();
        pulse_reset();
        drive(1'b1, 2'b10, 2'b10, 10'd0, 10'd3, '0, 64'd17);
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL st_gnt: got %b want 10", gnt); end
        total++; if (mem_we !== 1'b1 || mem_addr !== 10'd3 || mem_wdata !== 64'd17) begin
            bad++; $display("FAIL st_bus: got we=%b addr=%0d data=%0d want we=1 addr=3 data=17", mem_we, mem_addr, mem_wdata);
        end
        advance();
        drive(1'b1, 2'b01, 2'b00, 10'd3, 10'd0, '0, '0);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL ld_gnt: got %b want 01", gnt); end
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL st_no_rvalid: got %b want 00", rvalid); end
        advance();
        drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
        total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL ld_rvalid: got %b want 01", rvalid); end
        total++; if (rdata !== 64'd17) begin bad++; $display("FAIL ld_rdata: got %0d want 17", rdata); end
        advance();
    endtask

    task automatic test_reset_mid_read();
        pulse_reset();
        drive(1'b1, 2'b01, 2'b00, 10'd7, 10'd0, '0, '0);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL mid_gnt: got %b want 01", gnt); end
        advance();
        drive(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
        total++; if (rvalid !== 2'b00) begin bad++; $display("FAIL mid_rvalid: got %b want 00", rvalid); end
        advance();
        drive(1'b1, 2'b11, 2'b00, 10'd1, 10'd2, '0, '0);
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL mid_first_gnt: got %b want 01", gnt); end
        advance();
        drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
        total++; if (rvalid !== 2'b01 || rdata !== e_rdata) begin
            bad++; $display("FAIL mid_after_rd: got rv=%b data=%h want rv=01 data=%h", rvalid, rdata, e_rdata);
        end
        advance();
    endtask

    task automatic test_random();
        bit          ph [0:1];
        logic        pw [0:1];
        logic [AW-1:0] pa [0:1];
        logic [63:0] pd [0:1];
        logic        r;
        pulse_reset();
        for (int k = 0; k < 2; k++) begin ph[k] = 0; pw[k] = 0; pa[k] = '0; pd[k] = '0; end
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!ph[k] && $urandom_range(0, 2) != 0) begin
                    ph[k] = 1; pw[k] = 1'($urandom_range(0, 1));
                    pa[k] = AW'($urandom_range(0, 15)); pd[k] = {$urandom, $urandom};
                end else if (ph[k] && $urandom_range(0, 15) == 0) begin
                    ph[k] = 0;
                end
            end
            r = ($urandom_range(0, 39) != 0);
            drive(r, {ph[1], ph[0]}, {pw[1], pw[0]}, pa[0], pa[1], pd[0], pd[1]);
            total++; if (gnt !== e_gnt) begin bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, gnt, e_gnt); end
            total++; if (mem_en !== |e_gnt || mem_we !== e_we) begin
                bad++; $display("FAIL rnd_strobe[%0d]: got en=%b we=%b want en=%b we=%b", c, mem_en, mem_we, |e_gnt, e_we);
            end
            if (e_gnt != 2'b00) begin
                total++; if (mem_addr !== e_addr) begin bad++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", c, mem_addr, e_addr); end
                if (e_we) begin
                    total++; if (mem_wdata !== e_wdata) begin bad++; $display("FAIL rnd_wdata[%0d]: got %h want %h", c, mem_wdata, e_wdata); end
                end
            end
            total++; if (rvalid !== e_rvalid) begin bad++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, rvalid, e_rvalid); end
            if (e_rvalid != 2'b00) begin
                total++; if (rdata !== e_rdata) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, rdata, e_rdata); end
            end
            for (int k = 0; k < 2; k++) if (e_gnt[k] || !r) ph[k] = 0;
            advance();
        end
    endtask

    initial begin
        m_last = 1; m_wait = 0; m_pend = -1; m_pend_data = '0;
        for (int i = 0; i < 1024; i++) begin sh[i] = '0; shv[i] = 1'b0; end
        rst = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        cur_r = 1'b0; cur_req = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_load();
        test_contention();
`ifdef DMEM_ARB_RR_EN
        test_round_robin();
`endif
        test_store_load();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
